// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam int   MAX_N_CH   = 16;
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the search starts
// just after ptr, pick the lowest set bit, then rotate the index back.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  localparam int DW  = 2 * N_CH;
  localparam int SW1 = SEL_W + 1;

  logic [DW-1:0]    dbl_s;
  logic [N_CH-1:0]  rot_s;
  logic [SEL_W-1:0] start_s;
  logic [SEL_W-1:0] off_s;
  logic [SW1-1:0]   sum_s;
  logic             found_s;

  // Rotate, priority-encode, and map the offset back to a channel index
  always_comb begin
    start_s = '0;
    if (ptr >= SEL_W'(N_CH - 1)) begin
      start_s = '0;
    end else begin
      start_s = ptr + SEL_W'(1);
    end
    dbl_s   = {req, req};
    rot_s   = N_CH'(dbl_s >> start_s);
    off_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (rot_s[i] && !found_s) begin
        off_s   = SEL_W'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    sum_s = {1'b0, start_s} + {1'b0, off_s};
    if (sum_s >= SW1'(N_CH)) begin
      gnt_idx = SEL_W'(sum_s - SW1'(N_CH));
    end else begin
      gnt_idx = sum_s[SEL_W-1:0];
    end
    gnt_vld = found_s;
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed
// selection and a single registered output stage.
module rr_stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int WIDTH = 3,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic                    sel_mode,
  input  logic [SEL_W-1:0]        s,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  // Padding to a power of two keeps fixed-mode indexing in range when s >= N_CH
  localparam int NP  = 1 << SEL_W;
  localparam int DPW = NP * WIDTH;

  logic [NP-1:0]    valid_pad_s;
  logic [DPW-1:0]   data_pad_s;
  logic             load_en_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic             rr_vld_s;
  logic [SEL_W-1:0] grant_s;
  logic             grant_vld_s;
  logic [N_CH-1:0]  ready_s;
  logic [WIDTH-1:0] sel_data_s;

  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] out_ch_r;
  logic [SEL_W-1:0] rr_ptr_r;

  rr_arbiter #(
    .N_CH (N_CH),
    .SEL_W(SEL_W)
  ) u_arb (
    .req    (in_valid),
    .ptr    (rr_ptr_r),
    .gnt_idx(rr_idx_s),
    .gnt_vld(rr_vld_s)
  );

  // Mode mux: pick the grant source and the data it selects
  always_comb begin
    valid_pad_s = NP'(in_valid);
    data_pad_s  = DPW'(in_data);
    load_en_s   = !out_valid_r || out_ready;
    if (sel_mode == MODE_FIXED) begin
      grant_s     = s;
      grant_vld_s = valid_pad_s[s];
    end else begin
      grant_s     = rr_idx_s;
      grant_vld_s = rr_vld_s;
    end
    sel_data_s = data_pad_s[grant_s*WIDTH +: WIDTH];
  end

  // Ready decode: one-hot on the granted channel, suppressed during reset
  always_comb begin
    ready_s = '0;
    if (!rst && load_en_s && grant_vld_s) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Output stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      rr_ptr_r    <= SEL_W'(N_CH - 1);
    end else if (load_en_s) begin
      if (grant_vld_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
        out_ch_r    <= grant_s;
        if (sel_mode == MODE_RR) begin
          rr_ptr_r <= grant_s;
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_rr_stream_mux;

  logic        clk;
  logic        rst;
  logic [23:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        sel_mode;
  logic [2:0]  s;
  logic [2:0]  out_data;
  logic        out_valid;
  logic [2:0]  out_ch;
  logic        out_ready;

  logic        rst5;
  logic [14:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic        sel_mode5;
  logic [2:0]  s5;
  logic [2:0]  out_data5;
  logic        out_valid5;
  logic [2:0]  out_ch5;
  logic        out_ready5;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit       m_valid = 1'b0;
  int       m_data  = 0;
  int       m_ch    = 0;
  int       m_ptr   = 7;
  bit       p_gv;
  int       p_g;
  bit       p_ld;

  typedef struct {
    bit         rst;
    bit         mode;
    logic [2:0] s;
    logic [7:0] vld;
    bit         ordy;
    logic [7:0] e_rdy;
    bit         e_val;
    logic [2:0] e_ch;
    logic [2:0] e_dat;
  } vec_t;

  vec_t tbl[$];

  rr_stream_mux #(.N_CH(8), .WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel_mode(sel_mode), .s(s), .out_data(out_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
  );

  rr_stream_mux #(.N_CH(5), .WIDTH(3)) dut5 (
    .clk(clk), .rst(rst5), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .sel_mode(sel_mode5), .s(s5), .out_data(out_data5),
    .out_valid(out_valid5), .out_ch(out_ch5), .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit m, int sv, int v, bit o, int er, bit ev, int ec);
    vec_t t;
    t.rst = r; t.mode = m; t.s = 3'(sv); t.vld = 8'(v); t.ordy = o;
    t.e_rdy = 8'(er); t.e_val = ev; t.e_ch = 3'(ec); t.e_dat = 3'(ec);
    return t;
  endfunction

  // Grant from the rules: fixed index, or first valid channel after the pointer
  task automatic model_grant(output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (sel_mode) begin
      g  = int'(s);
      gv = in_valid[s];
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (in_valid[c] && !gv) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
  endtask

  task automatic pre_edge();
    int exp_rdy;
    #1;
    p_ld = !m_valid || out_ready;
    model_grant(p_gv, p_g);
    exp_rdy = (!rst && p_ld && p_gv) ? (1 << p_g) : 0;
    chk("ready", int'(in_ready), exp_rdy);
  endtask

  task automatic post_edge();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = 0; m_ch = 0; m_ptr = 7;
    end else if (p_ld) begin
      if (p_gv) begin
        m_valid = 1'b1;
        m_data  = int'(in_data[p_g*3 +: 3]);
        m_ch    = p_g;
        if (!sel_mode) m_ptr = p_g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_ch", int'(out_ch), m_ch);
    chk("out_data", int'(out_data), m_data);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 8; k++) in_data[k*3 +: 3] = 3'(k);
  endtask

  initial begin
    rst = 1'b1; sel_mode = 1'b0; s = 3'd0; in_valid = 8'h00; out_ready = 1'b1;
    in_data = 24'd0;
    rst5 = 1'b1; in_data5 = 15'd0; in_valid5 = 5'd0; sel_mode5 = 1'b0;
    s5 = 3'd0; out_ready5 = 1'b1;
    set_ramp();

    // Reset, full round-robin sweep, fixed select, sparse and wrap cases
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 8'h00, 0, 0));
    for (int k = 0; k < 9; k++) tbl.push_back(mk(0, 0, 0, 8'hFF, 1, 1 << (k % 8), 1, k % 8));
    tbl.push_back(mk(0, 1, 5, 8'h24, 1, 8'h20, 1, 5));
    tbl.push_back(mk(0, 1, 5, 8'h24, 1, 8'h20, 1, 5));
    tbl.push_back(mk(0, 0, 0, 8'hA0, 1, 8'h20, 1, 5));
    tbl.push_back(mk(0, 0, 0, 8'h40, 1, 8'h40, 1, 6));
    tbl.push_back(mk(0, 0, 0, 8'h48, 1, 8'h08, 1, 3));
    tbl.push_back(mk(0, 0, 0, 8'h48, 1, 8'h40, 1, 6));
    tbl.push_back(mk(0, 0, 0, 8'h48, 1, 8'h08, 1, 3));
    tbl.push_back(mk(0, 0, 0, 8'h80, 1, 8'h80, 1, 7));
    tbl.push_back(mk(0, 0, 0, 8'h09, 1, 8'h01, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h04, 0, 8'h04, 1, 2));
    tbl.push_back(mk(0, 0, 0, 8'h04, 0, 8'h00, 1, 2));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; sel_mode = tbl[i].mode; s = tbl[i].s;
      in_valid = tbl[i].vld; out_ready = tbl[i].ordy;
      pre_edge();
      chk($sformatf("vec%0d_rdy", i), int'(in_ready), int'(tbl[i].e_rdy));
      post_edge();
      chk($sformatf("vec%0d_val", i), int'(out_valid), int'(tbl[i].e_val));
      chk($sformatf("vec%0d_ch", i), int'(out_ch), int'(tbl[i].e_ch));
      chk($sformatf("vec%0d_dat", i), int'(out_data), int'(tbl[i].e_dat));
    end

    // Back-pressure: word from ch2 held for 4 cycles, then reload without a bubble
    in_valid = 8'hFF; out_ready = 1'b0; sel_mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pre_edge();
      chk("bp_rdy_zero", int'(in_ready), 0);
      post_edge();
      chk("bp_hold_ch", int'(out_ch), 2);
      chk("bp_hold_dat", int'(out_data), 2);
    end
    out_ready = 1'b1;
    pre_edge();
    chk("bp_reload_rdy", int'(in_ready), 8);
    post_edge();
    chk("bp_reload_ch", int'(out_ch), 3);
    chk("bp_reload_val", int'(out_valid), 1);

    // Mid-operation reset with a held word and ch4 requesting
    in_valid = 8'h10; out_ready = 1'b0;
    pre_edge();
    post_edge();
    rst = 1'b1;
    pre_edge();
    chk("rst_rdy", int'(in_ready), 0);
    post_edge();
    chk("rst_val", int'(out_valid), 0);
    chk("rst_dat", int'(out_data), 0);
    rst = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    pre_edge();
    chk("rst_prio_rdy", int'(in_ready), 1);
    post_edge();
    chk("rst_prio_ch", int'(out_ch), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 31) == 0);
      sel_mode  = ($urandom_range(0, 3) == 0);
      s         = 3'($urandom_range(0, 7));
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 24'($urandom);
      pre_edge();
      post_edge();
    end

    // Five-channel instance: select beyond the channel count never grants
    rst5 = 1'b1;
    @(posedge clk); #1;
    rst5 = 1'b0; sel_mode5 = 1'b1; s5 = 3'd2; in_valid5 = 5'h1F; out_ready5 = 1'b1;
    in_data5 = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    #1;
    chk("n5_rdy_s2", int'(in_ready5), 4);
    @(posedge clk); #1;
    chk("n5_val_s2", int'(out_valid5), 1);
    chk("n5_ch_s2", int'(out_ch5), 2);
    s5 = 3'd6;
    #1;
    chk("n5_rdy_s6", int'(in_ready5), 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("n5_val_s6", int'(out_valid5), 0);
      chk("n5_hold_ch", int'(out_ch5), 2);
      chk("n5_hold_dat", int'(out_data5), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
